// File: rtl/maj_checker.sv
// maj_checker: checks a 3-input majority unit against its reference function.
// It counts samples and mismatches, tracks which input codes have been seen,
// and records the first failing code. A run ends when all eight codes have been
// seen, or at the first mismatch when STOP_ON_FAIL is set.
//
// Ports:
//   clk              clock; all state updates on its rising edge
//   rst              synchronous active-high reset
//   start            begin a new run from IDLE or DONE; clears statistics
//   in_valid         sample (inp, f) presented
//   inp[2:0]         input code applied to the unit under test
//   f                unit-under-test output for inp
//   in_ready         sample accepted this cycle (RUN only)
//   busy             in RUN
//   done             run complete; held until start or rst
//   pass             valid with done: no mismatches and full coverage
//   sample_cnt       accepted samples, saturating
//   fail_cnt         mismatching samples, saturating
//   cov_map[7:0]     bit k set once code k has been accepted
//   first_fail_inp   inp of the first mismatch in the run
//   first_fail_valid first_fail_inp holds a captured value
module maj_checker #(
  parameter int unsigned CNT_W        = 8,
  parameter bit          STOP_ON_FAIL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [2:0]       inp,
  input  logic             f,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [7:0]       cov_map,
  output logic [2:0]       first_fail_inp,
  output logic             first_fail_valid
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic [7:0]       cov_q, cov_d;
  logic [2:0]       ff_inp_q, ff_inp_d;
  logic             ff_valid_q, ff_valid_d;
  logic             pass_q, pass_d;

  logic             accept;
  logic             exp_f;
  logic             mismatch;

  assign exp_f    = (inp[0] & inp[1]) | (inp[1] & inp[2]) | (inp[0] & inp[2]);
  assign accept   = (state_q == StRun) && in_valid;
  assign mismatch = accept && (f != exp_f);

  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    fail_cnt_d   = fail_cnt_q;
    cov_d        = cov_q;
    ff_inp_d     = ff_inp_q;
    ff_valid_d   = ff_valid_q;
    pass_d       = pass_q;

    case (state_q)
      StIdle, StDone: begin
        // Any sample presented alongside start is dropped: in_ready is low here.
        if (start) begin
          state_d      = StRun;
          sample_cnt_d = '0;
          fail_cnt_d   = '0;
          cov_d        = '0;
          ff_inp_d     = '0;
          ff_valid_d   = 1'b0;
          pass_d       = 1'b0;
        end
      end
      StRun: begin
        if (accept) begin
          cov_d = cov_q | (8'd1 << inp);
          if (sample_cnt_q != {CNT_W{1'b1}}) begin
            sample_cnt_d = sample_cnt_q + CNT_W'(1);
          end
          if (mismatch) begin
            if (fail_cnt_q != {CNT_W{1'b1}}) begin
              fail_cnt_d = fail_cnt_q + CNT_W'(1);
            end
            if (!ff_valid_q) begin
              ff_inp_d   = inp;
              ff_valid_d = 1'b1;
            end
          end
          // Verdict uses the post-update values so the final sample counts.
          if ((cov_d == 8'hFF) || (STOP_ON_FAIL && mismatch)) begin
            state_d = StDone;
            pass_d  = (fail_cnt_d == '0) && (cov_d == 8'hFF);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      sample_cnt_q <= '0;
      fail_cnt_q   <= '0;
      cov_q        <= '0;
      ff_inp_q     <= '0;
      ff_valid_q   <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      fail_cnt_q   <= fail_cnt_d;
      cov_q        <= cov_d;
      ff_inp_q     <= ff_inp_d;
      ff_valid_q   <= ff_valid_d;
      pass_q       <= pass_d;
    end
  end

  assign in_ready         = (state_q == StRun);
  assign busy             = (state_q == StRun);
  assign done             = (state_q == StDone);
  assign pass             = pass_q;
  assign sample_cnt       = sample_cnt_q;
  assign fail_cnt         = fail_cnt_q;
  assign cov_map          = cov_q;
  assign first_fail_inp   = ff_inp_q;
  assign first_fail_valid = ff_valid_q;

endmodule

// File: doc/maj_checker.md
MAJ_CHECKER -- requirements
Module: maj_checker

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, giving the width of the sample and fail counters.
REQ-002 The block SHALL have parameter STOP_ON_FAIL, default 0; when 1, the first mismatch ends the run.
REQ-003 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 start  input  1  begin a new run; clears statistics.
REQ-006 in_valid  input  1  a sample (inp, f) is presented.
REQ-007 inp  input  3  the 3-bit input code applied to the majority unit under test.
REQ-008 f  input  1  the output of the unit under test for inp.
REQ-009 in_ready  output  1  the checker accepts a sample this cycle.
REQ-010 busy  output  1  the checker is in RUN.
REQ-011 done  output  1  the run is complete; held until the next start or rst.
REQ-012 pass  output  1  valid while done=1; 1 = no mismatches and all 8 codes covered.
REQ-013 sample_cnt  output  CNT_W  number of accepted samples, saturating.
REQ-014 fail_cnt  output  CNT_W  number of mismatching samples, saturating.
REQ-015 cov_map  output  8  bit k set = code k has been accepted at least once.
REQ-016 first_fail_inp  output  3  inp of the first mismatch in the run.
REQ-017 first_fail_valid  output  1  first_fail_inp holds a captured value.

Function
REQ-018 Expected output SHALL be the majority function: exp = (inp[0]&inp[1]) | (inp[1]&inp[2]) | (inp[0]&inp[2]).
REQ-019 The FSM SHALL have exactly three states: IDLE, RUN, DONE; busy=1 only in RUN, done=1 only in DONE.
REQ-020 in_ready SHALL be 1 in RUN and 0 in IDLE and DONE; a sample is accepted only when in_valid & in_ready.
REQ-021 IDLE or DONE with start=1 -> RUN next cycle, with all counters, cov_map, first_fail_valid, first_fail_inp and pass cleared.
REQ-022 start in RUN SHALL be ignored.
REQ-023 An accepted sample SHALL set cov_map[inp], increment sample_cnt, and increment fail_cnt if f != exp; all of these are visible the cycle after acceptance (1-cycle latency).
REQ-024 On the first mismatch of a run, first_fail_inp SHALL capture inp and first_fail_valid SHALL set; later mismatches SHALL NOT overwrite it.
REQ-025 RUN -> DONE the cycle after the accepted sample that makes cov_map all-ones (including that sample's update).
REQ-026 With STOP_ON_FAIL=1, RUN -> DONE the cycle after the first mismatching accepted sample, regardless of coverage.
REQ-027 On entry to DONE, pass SHALL be 1 iff fail_cnt==0 and cov_map==8'hFF (both after the final sample's update).
REQ-028 A repeated code SHALL still increment sample_cnt and be checked, and SHALL leave cov_map unchanged.
REQ-029 sample_cnt and fail_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-030 A sample that both completes coverage and mismatches SHALL be counted as a fail, and DONE SHALL be entered with pass=0.
REQ-031 in_valid in IDLE or DONE SHALL have no effect on any output.
REQ-032 If start and in_valid are both asserted in IDLE or DONE, only the state change SHALL occur; the sample SHALL NOT be accepted.

Reset
REQ-033 rst=1 SHALL force IDLE next edge, overriding start and in_valid.
REQ-034 In reset, all outputs SHALL be 0: in_ready, busy, done, pass, sample_cnt, fail_cnt, cov_map, first_fail_inp and first_fail_valid.
REQ-035 rst during RUN SHALL discard the run in progress; a sample presented in that same cycle SHALL NOT be counted.

Verification
REQ-036 Correct inp 0..7 in order, one per cycle -> done=1 one cycle after the 8th accept; pass=1, sample_cnt=8, fail_cnt=0, cov_map=FF.
REQ-037 Same stream with f inverted at inp=3 and inp=5 -> fail_cnt=2, first_fail_inp=3, first_fail_valid=1, pass=0.
REQ-038 Correct stream 0,0,1,2,...,7 -> sample_cnt=9, done only after the 9th accept, pass=1.
REQ-039 STOP_ON_FAIL=1, first sample inp=7, f=0 -> done next cycle, sample_cnt=1, fail_cnt=1, cov_map=80, pass=0.
REQ-040 rst after 4 accepted samples -> all outputs 0 and in_ready=0 next cycle; a new start then restarts with clean counters.
REQ-041 CNT_W=2, code 0 correct 5 times -> sample_cnt saturates at 3, cov_map=01, no done.
